dac_sar_ctrl: RTL and testbench

Successive-approximation sequencer for the chip's resistor-string DAC and comparator. On a start request it holds the input in track mode for a programmable window, then walks the DAC code MSB-first, sampling the comparator after a programmable settle time per bit, and delivers an N-bit result with a one-cycle done pulse. It sits between the serial configuration/pad logic and the DAC switch-select outputs, and replaces direct pad-driven selection when conversion mode is in use.

---
 rtl/dac_ctrl_pkg.sv | 17 +
 rtl/dac_sar_ctrl_dwell_timer.sv | 34 +++
 rtl/dac_sar_ctrl.sv | 157 +++++++++++++++
 tb/tb_dac_sar_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/dac_ctrl_pkg.sv
// dac_ctrl_pkg
//   Shared definitions for the SAR DAC sequencer: the FSM state type and
//   the default build constants (resolution, sample window, settle time).
package dac_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    CONV   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int N_DEF          = 4;
  localparam int SAMPLE_CYC_DEF = 2;
  localparam int SETTLE_DEF     = 1;

endpackage

// File: rtl/dac_sar_ctrl_dwell_timer.sv
// dwell_timer
//   Loadable down-counter with a zero flag.  It times both the track window
//   and the per-bit settle window of the SAR sequencer.
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     load        load load_val this edge (takes priority over counting)
//     load_val    value to load
//     zero        high while the count is zero
module dwell_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // Count down and park at zero until the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/dac_sar_ctrl.sv
// dac_sar_ctrl
//   Successive-approximation sequencer for the resistor-string DAC and
//   comparator.  On start it tracks the input for SAMPLE_CYC cycles, then
//   tries each DAC bit MSB-first, holding each trial code SETTLE+1 cycles
//   and deciding on the last edge of that window.  The N-bit result is
//   published together with a one-cycle done pulse.
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     start       conversion request (looked at in IDLE/DONE only)
//     abort       synchronous cancel, returns to IDLE without done
//     comp        comparator, 1 = input >= current DAC output
//     sample      track/hold control, 1 = track
//     dac_code    DAC switch-select code (registered)
//     busy        high in SAMPLE and CONV
//     done        one-cycle pulse when result updates
//     result      last completed conversion
module dac_sar_ctrl
  import dac_ctrl_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int SAMPLE_CYC = SAMPLE_CYC_DEF,
  parameter int SETTLE     = SETTLE_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic         comp,
  output logic         sample,
  output logic [N-1:0] dac_code,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int MAX_DWELL = (SAMPLE_CYC > SETTLE + 1) ? SAMPLE_CYC : SETTLE + 1;
  localparam int CW        = $clog2(MAX_DWELL) + 1;
  localparam int IW        = $clog2(N);

  localparam logic [CW-1:0] SAMPLE_LOAD = CW'(SAMPLE_CYC - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE);
  localparam logic [N-1:0]  MSB_TRIAL   = {1'b1, {(N-1){1'b0}}};
  localparam logic [IW-1:0] MSB_IDX     = IW'(N - 1);

  state_t        state;
  logic [IW-1:0] idx;
  logic [N-1:0]  trial;
  logic [N-1:0]  decided;
  logic [N-1:0]  next_trial;
  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic          tmr_zero;

  dwell_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Timer reloads line up with the FSM transitions: the track window on a
  // start, and a fresh settle window on entry to CONV and after every
  // non-final bit decision.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = SETTLE_LOAD;
    if (!abort) begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            tmr_load = 1'b1;
            tmr_val  = SAMPLE_LOAD;
          end
        end
        SAMPLE:  tmr_load = tmr_zero;
        CONV:    tmr_load = tmr_zero && (idx != '0);
        default: tmr_load = 1'b0;
      endcase
    end
  end

  // Trial register after the decision on the current bit: keep or clear
  // bit[idx] by the comparator, then arm the next lower bit.
  always_comb begin
    decided      = trial;
    decided[idx] = comp;
    next_trial   = decided;
    if (idx != '0) begin
      next_trial[idx - IW'(1)] = 1'b1;
    end
  end

  // Sequencer FSM.  All outputs are registered here so comp never reaches
  // an output combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      trial    <= '0;
      sample   <= 1'b0;
      dac_code <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
    end else if (abort) begin
      state    <= IDLE;
      sample   <= 1'b0;
      dac_code <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          dac_code <= '0;
          if (start) begin
            state  <= SAMPLE;
            sample <= 1'b1;
            busy   <= 1'b1;
          end else begin
            state  <= IDLE;
            sample <= 1'b0;
            busy   <= 1'b0;
          end
        end
        SAMPLE: begin
          if (tmr_zero) begin
            state    <= CONV;
            sample   <= 1'b0;
            idx      <= MSB_IDX;
            trial    <= MSB_TRIAL;
            dac_code <= MSB_TRIAL;
          end
        end
        CONV: begin
          if (tmr_zero) begin
            if (idx != '0) begin
              idx      <= idx - IW'(1);
              trial    <= next_trial;
              dac_code <= next_trial;
            end else begin
              state    <= DONE;
              trial    <= decided;
              result   <= decided;
              dac_code <= decided;
              busy     <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_sar_ctrl.sv
// tb_dac_sar_ctrl
//   Directed bench for dac_sar_ctrl.  A default build (N=4, SAMPLE_CYC=2,
//   SETTLE=1) and a fast build (SAMPLE_CYC=1, SETTLE=0) share the clock and
//   reset; sel chooses which one is driven and observed.  The comparator is
//   modelled from an analog input code, and is deliberately driven to the
//   wrong value between decision edges.
module tb_dac_sar_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       comp;
  logic       sel;

  logic       start1, start2;
  logic       samp1, samp2, busy1, busy2, done1, done2;
  logic [3:0] code1, code2, res1, res2;

  logic       samp_m, busy_m, done_m;
  logic [3:0] code_m, res_m;

  int checks;
  int failures;

  assign start1 = start & ~sel;
  assign start2 = start & sel;
  assign samp_m = sel ? samp2 : samp1;
  assign busy_m = sel ? busy2 : busy1;
  assign done_m = sel ? done2 : done1;
  assign code_m = sel ? code2 : code1;
  assign res_m  = sel ? res2  : res1;

  dac_sar_ctrl #(.N(4), .SAMPLE_CYC(2), .SETTLE(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start1),
    .abort    (abort),
    .comp     (comp),
    .sample   (samp1),
    .dac_code (code1),
    .busy     (busy1),
    .done     (done1),
    .result   (res1)
  );

  dac_sar_ctrl #(.N(4), .SAMPLE_CYC(1), .SETTLE(0)) dut_fast (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start2),
    .abort    (abort),
    .comp     (comp),
    .sample   (samp2),
    .dac_code (code2),
    .busy     (busy2),
    .done     (done2),
    .result   (res2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag, input logic [3:0] expRes);
    @(negedge clk);
    checkOutput({tag, "_done"},   8'(done_m), 8'h0);
    checkOutput({tag, "_busy"},   8'(busy_m), 8'h0);
    checkOutput({tag, "_sample"}, 8'(samp_m), 8'h0);
    checkOutput({tag, "_code"},   8'(code_m), 8'h0);
    checkOutput({tag, "_result"}, 8'(res_m),  8'(expRes));
  endtask

  // One full conversion starting from IDLE/DONE.  expRes and expL are the
  // hand-worked result and done cycle; the per-cycle DAC codes follow the
  // SAR trial sequence for analog input vin.  cmode: 0 model, 1 comp=1,
  // 2 comp=0.
  task automatic applyStimulus(input logic [3:0] vin, input int cmode, input bit keepStart,
                               input logic [3:0] prevRes, input logic [3:0] expRes,
                               input int expL);
    int         sc, st, b;
    logic [3:0] trial;
    logic       mc;
    bit         decide;
    string      t;
    sc    = sel ? 1 : 2;
    st    = sel ? 0 : 1;
    trial = 4'b1000;
    b     = 3;
    start = 1'b1;
    for (int c = 0; c <= expL; c++) begin
      @(posedge clk);
      #1 comp = ~comp;
      @(negedge clk);
      if (c == 0 && !keepStart) start = 1'b0;
      t = $sformatf("v%0h_c%0d", vin, c);
      decide = 1'b0;
      if (c < sc) begin
        checkOutput({t, "_code"},   8'(code_m), 8'h0);
        checkOutput({t, "_sample"}, 8'(samp_m), 8'h1);
        checkOutput({t, "_busy"},   8'(busy_m), 8'h1);
        checkOutput({t, "_done"},   8'(done_m), 8'h0);
      end else if (c < expL) begin
        checkOutput({t, "_code"},   8'(code_m), 8'(trial));
        checkOutput({t, "_sample"}, 8'(samp_m), 8'h0);
        checkOutput({t, "_busy"},   8'(busy_m), 8'h1);
        checkOutput({t, "_done"},   8'(done_m), 8'h0);
        decide = ((c - sc) % (st + 1)) == st;
      end else begin
        checkOutput({t, "_done"},   8'(done_m), 8'h1);
        checkOutput({t, "_busy"},   8'(busy_m), 8'h0);
        checkOutput({t, "_sample"}, 8'(samp_m), 8'h0);
        checkOutput({t, "_code"},   8'(code_m), 8'(expRes));
        checkOutput({t, "_result"}, 8'(res_m),  8'(expRes));
        checkOutput({t, "_model"},  8'(trial),  8'(expRes));
      end
      if (c == expL - 1) checkOutput({t, "_result_held"}, 8'(res_m), 8'(prevRes));
      mc = (cmode == 1) ? 1'b1 : (cmode == 2) ? 1'b0 : (vin >= trial);
      comp = decide ? mc : ~mc;
      if (decide) begin
        if (!mc) trial[b] = 1'b0;
        if (b > 0) trial[b-1] = 1'b1;
        b--;
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    comp     = 1'b0;
    sel      = 1'b0;

    #1;
    checkOutput("rst_code",   8'(code1), 8'h0);
    checkOutput("rst_sample", 8'(samp1), 8'h0);
    checkOutput("rst_busy",   8'(busy1), 8'h0);
    checkOutput("rst_done",   8'(done1), 8'h0);
    checkOutput("rst_result", 8'(res1),  8'h0);
    checkOutput("rst_result_fast", 8'(res2), 8'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Input 0xA: codes 0,0,8,8,12,12,10,10,11,11,10, done at cycle 10.
    applyStimulus(4'hA, 0, 1'b0, 4'h0, 4'hA, 10);
    checkIdle("after_A", 4'hA);

    // Comparator stuck high / low.
    applyStimulus(4'h0, 1, 1'b0, 4'hA, 4'hF, 10);
    checkIdle("after_hi", 4'hF);
    applyStimulus(4'h0, 2, 1'b0, 4'hF, 4'h0, 10);
    checkIdle("after_lo", 4'h0);

    // start held: done every 11 cycles.
    applyStimulus(4'h5, 0, 1'b1, 4'h0, 4'h5, 10);
    applyStimulus(4'hC, 0, 1'b1, 4'h5, 4'hC, 10);
    applyStimulus(4'h3, 0, 1'b0, 4'hC, 4'h3, 10);
    checkIdle("after_b2b", 4'h3);

    // abort with start in IDLE: abort wins.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    checkOutput("abort_start_busy",   8'(busy_m), 8'h0);
    checkOutput("abort_start_sample", 8'(samp_m), 8'h0);
    start = 1'b0;
    abort = 1'b0;

    // abort during cycle 5 of a conversion.
    start = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      comp  = 1'b0;
    end
    abort = 1'b1;
    checkOutput("pre_abort_busy", 8'(busy_m), 8'h1);
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_busy",   8'(busy_m), 8'h0);
    checkOutput("abort_sample", 8'(samp_m), 8'h0);
    checkOutput("abort_code",   8'(code_m), 8'h0);
    checkOutput("abort_done",   8'(done_m), 8'h0);
    checkOutput("abort_result", 8'(res_m),  8'h3);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput($sformatf("abort_nodone_%0d", c), 8'(done_m), 8'h0);
    end
    applyStimulus(4'h6, 0, 1'b0, 4'h3, 4'h6, 10);
    checkIdle("after_abort", 4'h6);

    // Asynchronous reset mid-CONV, between edges.
    start = 1'b1;
    for (int c = 0; c <= 3; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checkOutput("pre_rst_code", 8'(code_m), 8'h8);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_code",   8'(code_m), 8'h0);
    checkOutput("arst_busy",   8'(busy_m), 8'h0);
    checkOutput("arst_sample", 8'(samp_m), 8'h0);
    checkOutput("arst_result", 8'(res_m),  8'h0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(4'h5, 0, 1'b0, 4'h0, 4'h5, 10);
    checkIdle("after_arst", 4'h5);

    // Fast build: L = 5, comp toggled between every decision edge.
    sel = 1'b1;
    @(negedge clk);
    applyStimulus(4'h9, 0, 1'b0, 4'h0, 4'h9, 5);
    checkIdle("fast_9", 4'h9);
    applyStimulus(4'h6, 0, 1'b0, 4'h9, 4'h6, 5);
    checkIdle("fast_6", 4'h6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
